// File: rtl/type_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : type_pkg
//  Description : Shared core types: address/data words, fetch FSM states,
//                and the {pc, instruction} packet buffered by fetch.
//  Revision    : 1.0  initial release
// ============================================================================
package type_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    // Byte stride between sequential instructions.
    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        addr_t pc;
        data_t inst;
    } inst_pkt_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO of inst_pkt_t entries with flush.
//                Head entry is presented combinationally on rdata_o.
//  Ports       : clk, rst (async, active-high)
//                push_i/wdata_i  - enqueue
//                pop_i           - dequeue head
//                flush_i         - empty the FIFO (overrides push/pop)
//                rdata_o         - head entry
//                full_o, empty_o, count_o - occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo
    import type_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    input  inst_pkt_t                   wdata_i,
    output inst_pkt_t                   rdata_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    inst_pkt_t          mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch front end. Holds the fetch PC, keeps at
//                most one icache read outstanding, buffers {pc, inst} pairs
//                for decode, and handles branch/jump redirects.
//  Ports       : clk, rst (async, active-high)
//                redirect_valid/redirect_pc       - redirect from execute
//                icache_req/icache_addr (out)     - registered fetch request
//                icache_data/icache_valid (in)    - one-cycle response
//                inst_valid/inst_data/inst_pc     - FIFO head to decode
//                inst_ready                        - decode accepts head
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import type_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter addr_t       RESET_PC = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    redirect_valid,
    input  addr_t   redirect_pc,
    output logic    icache_req,
    output data_t   icache_addr,
    input  data_t   icache_data,
    input  logic    icache_valid,
    output logic    inst_valid,
    output data_t   inst_data,
    output addr_t   inst_pc,
    input  logic    inst_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam addr_t STRIDE = addr_t'(INST_BYTES);

    fetch_state_t   state_q, state_d;
    addr_t          pc_q,    pc_d;
    logic           req_q,   req_d;
    addr_t          addr_q,  addr_d;

    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  count_after;
    inst_pkt_t      fifo_wdata;
    inst_pkt_t      fifo_head;

    // A redirect flushes the FIFO, so it also suppresses any push or pop.
    assign fifo_push  = (state_q == REQ) && icache_valid && !redirect_valid;
    assign fifo_pop   = inst_valid && inst_ready && !redirect_valid;
    assign fifo_wdata = '{pc: addr_q, inst: icache_data};

    // Occupancy once this cycle's push/pop have landed; never exceeds DEPTH
    // because a request is only issued while there is room.
    assign count_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;

        if (redirect_valid) begin
            pc_d = redirect_pc;
            unique case (state_q)
                REQ, DROP: begin
                    // The outstanding cache handshake must still complete;
                    // its data is thrown away.
                    if (icache_valid) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_full) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (icache_valid) begin
                        pc_d = addr_q + STRIDE;
                        if (count_after < DEPTH_C) begin
                            // Back-to-back request to the next sequential PC.
                            addr_d = addr_q + STRIDE;
                        end else begin
                            req_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (icache_valid) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    sync_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect_valid),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign icache_req  = req_q;
    assign icache_addr = addr_q;
    assign inst_valid  = !fifo_empty;
    assign inst_data   = fifo_head.inst;
    assign inst_pc     = fifo_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit (DEPTH=4,
//                RESET_PC=0). Icache responses are driven by hand from the
//                main stimulus block; expected values are hand-computed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic [31:0] icache_data;
    logic        icache_valid;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int n_vec;
    int n_err;

    fetch_unit #(
        .DEPTH          (4),
        .RESET_PC       (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_data    (icache_data),
        .icache_valid   (icache_valid),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the "memory" holds at a given address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        icache_valid   = 1'b0;
        icache_data    = 32'h0;
        inst_ready     = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Answer the current request in this cycle with the memory word for a.
    task automatic respond(input logic [31:0] a);
        icache_valid = 1'b1;
        icache_data  = mem_word(a);
        step();
        icache_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_req",   32'(icache_req), 32'd0);
        chk("rst_addr",  icache_addr,     32'h0);
        chk("rst_valid", 32'(inst_valid), 32'd0);

        // ---------------- streaming ----------------
        inst_ready = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk("str_req",  32'(icache_req), 32'd1);
            chk("str_addr", icache_addr,     32'(4 * i));
            if (i > 0) begin
                chk("str_ivalid", 32'(inst_valid), 32'd1);
                chk("str_ipc",    inst_pc,         32'(4 * (i - 1)));
                chk("str_idata",  inst_data,       mem_word(32'(4 * (i - 1))));
            end
            respond(32'(4 * i));
        end

        // ---------------- backpressure ----------------
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            chk("bp_req",  32'(icache_req), 32'd1);
            chk("bp_addr", icache_addr,     32'(4 * i));
            respond(32'(4 * i));
        end
        chk("bp_full_req", 32'(icache_req), 32'd0);
        chk("bp_ivalid",   32'(inst_valid), 32'd1);
        chk("bp_ipc0",     inst_pc,         32'h0);
        step();
        chk("bp_hold_req", 32'(icache_req), 32'd0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("bp_pop_req", 32'(icache_req), 32'd0);
        chk("bp_ipc1",    inst_pc,         32'h4);
        step();
        chk("bp_new_req",  32'(icache_req), 32'd1);
        chk("bp_new_addr", icache_addr,     32'h10);
        respond(32'h10);
        chk("bp_refull_req", 32'(icache_req), 32'd0);
        chk("bp_ipc1b",      inst_pc,         32'h4);

        // ---------------- redirect while request pending ----------------
        do_reset();
        inst_ready = 1'b1;
        step();
        respond(32'h0);
        respond(32'h4);
        chk("rp_addr8", icache_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("rp_drop_req",  32'(icache_req), 32'd1);
        chk("rp_drop_addr", icache_addr,     32'h8);
        chk("rp_flushed",   32'(inst_valid), 32'd0);
        step();
        chk("rp_hold_addr1", icache_addr, 32'h8);
        step();
        chk("rp_hold_addr2", icache_addr, 32'h8);
        icache_valid = 1'b1;
        icache_data  = 32'hBAD0_0008;
        step();
        icache_valid = 1'b0;
        chk("rp_done_req", 32'(icache_req), 32'd0);
        chk("rp_empty",    32'(inst_valid), 32'd0);
        step();
        chk("rp_new_req",  32'(icache_req), 32'd1);
        chk("rp_new_addr", icache_addr,     32'h100);
        respond(32'h100);
        chk("rp_ivalid", 32'(inst_valid), 32'd1);
        chk("rp_ipc",    inst_pc,         32'h100);
        chk("rp_idata",  inst_data,       mem_word(32'h100));

        // ---------------- redirect coinciding with response ----------------
        do_reset();
        inst_ready = 1'b1;
        step();
        respond(32'h0);
        respond(32'h4);
        chk("rc_addr8", icache_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        respond(32'h8);
        redirect_valid = 1'b0;
        chk("rc_req",    32'(icache_req), 32'd0);
        chk("rc_flush",  32'(inst_valid), 32'd0);
        step();
        chk("rc_new_req",  32'(icache_req), 32'd1);
        chk("rc_new_addr", icache_addr,     32'h200);
        respond(32'h200);
        chk("rc_ipc",   inst_pc,   32'h200);
        chk("rc_idata", inst_data, mem_word(32'h200));

        // ---------------- PC wrap (redirect from IDLE) ----------------
        do_reset();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wr_idle_req", 32'(icache_req), 32'd0);
        step();
        chk("wr_req",  32'(icache_req), 32'd1);
        chk("wr_addr", icache_addr,     32'hFFFF_FFFC);
        respond(32'hFFFF_FFFC);
        chk("wr_addr0", icache_addr, 32'h0);
        chk("wr_ipc",   inst_pc,     32'hFFFF_FFFC);
        respond(32'h0);
        chk("wr_ipc0",   inst_pc,   32'h0);
        chk("wr_idata0", inst_data, mem_word(32'h0));

        // ---------------- reset mid-operation ----------------
        do_reset();
        step();
        respond(32'h0);
        respond(32'h4);
        respond(32'h8);
        chk("rm_pend_addr", icache_addr,     32'hC);
        chk("rm_pend_req",  32'(icache_req), 32'd1);
        chk("rm_ivalid",    32'(inst_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_async_req",    32'(icache_req), 32'd0);
        chk("rm_async_ivalid", 32'(inst_valid), 32'd0);
        chk("rm_async_addr",   icache_addr,     32'h0);
        step();
        rst = 1'b0;
        step();
        chk("rm_first_req",  32'(icache_req), 32'd1);
        chk("rm_first_addr", icache_addr,     32'h0);
        chk("rm_ivalid0",    32'(inst_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
